// File: rtl/axi_msg_pkg.sv
// ============================================================================
// Module      : axi_msg_pkg
// Description : Shared types and field positions for the message responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_msg_pkg;

    localparam int W_MSG = 64;

    // Field positions, shared by request and response words
    localparam int OP_MSB   = 63;
    localparam int OP_LSB   = 60;
    localparam int ST_MSB   = 59;
    localparam int ST_LSB   = 56;
    localparam int ADDR_MSB = 55;
    localparam int ADDR_LSB = 48;
    localparam int TAG_MSB  = 47;
    localparam int TAG_LSB  = 32;
    localparam int DATA_MSB = 31;
    localparam int DATA_LSB = 0;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_WRITE = 4'd1,
        OP_READ  = 4'd2,
        OP_ADD   = 4'd3
    } op_e;

    typedef enum logic [3:0] {
        ST_OK       = 4'd0,
        ST_BAD_ADDR = 4'd1,
        ST_BAD_OP   = 4'd2
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_EXEC = 2'd2,
        S_RESP = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/msg_regfile.sv
// ============================================================================
// Module      : msg_regfile
// Description : N_REGS x 32 register file, combinational read, synchronous
//               write, synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module msg_regfile #(
    parameter int N_REGS     = 16,
    parameter int W_LOG_REGS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W_LOG_REGS-1:0] i_rd_addr,
    output logic [31:0]           o_rd_data,
    input  logic                  i_we,
    input  logic [W_LOG_REGS-1:0] i_wr_addr,
    input  logic [31:0]           i_wr_data
);

    logic [31:0] r_regs [N_REGS];

    // Write port; reset clears every entry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REGS; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (i_we) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_regs[i_rd_addr];

endmodule

`default_nettype wire

// File: rtl/axi_msg_responder.sv
// ============================================================================
// Module      : axi_msg_responder
// Description : Pops request messages from the bridge IN FIFO, executes them
//               against a small register file and pushes one response each.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_msg_responder
    import axi_msg_pkg::*;
#(
    parameter int W_MSG      = 64,
    parameter int N_REGS     = 16,
    parameter int W_LOG_REGS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_in_msg_rdy,
    input  logic [W_MSG-1:0] i_in_msg,
    output logic             i_in_msg_ack,
    output logic             i_out_msg_rdy,
    output logic [W_MSG-1:0] i_out_msg,
    input  logic             i_out_msg_ack,
    output logic             busy,
    output logic [15:0]      n_msgs,
    output logic [15:0]      n_errs
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [W_MSG-1:0] r_msg_q;
    logic [W_MSG-1:0] r_resp;
    logic [15:0]      r_n_msgs;
    logic [15:0]      r_n_errs;

    logic [3:0]  w_op;
    logic [7:0]  w_addr;
    logic [15:0] w_tag;
    logic [31:0] w_data;
    logic [31:0] w_rd_data;
    logic [31:0] w_sum;
    logic [31:0] w_result;
    logic [31:0] w_wdata;
    logic        w_we;
    logic        w_bad_addr;
    status_e     w_status;
    logic        w_unused_rsvd;

    assign w_op          = r_msg_q[OP_MSB:OP_LSB];
    assign w_addr        = r_msg_q[ADDR_MSB:ADDR_LSB];
    assign w_tag         = r_msg_q[TAG_MSB:TAG_LSB];
    assign w_data        = r_msg_q[DATA_MSB:DATA_LSB];
    // Reserved request bits carry no meaning; the response reuses them for status
    assign w_unused_rsvd = ^r_msg_q[ST_MSB:ST_LSB];

    assign w_bad_addr = ({24'd0, w_addr} >= 32'(N_REGS));
    assign w_sum      = w_rd_data + w_data;

    // Decode the captured request into status, result and write strobe
    always_comb begin
        w_status = ST_OK;
        w_result = 32'd0;
        w_wdata  = w_data;
        w_we     = 1'b0;
        if (w_op > 4'd3) begin
            w_status = ST_BAD_OP;
        end else if (w_op != OP_NOP && w_bad_addr) begin
            w_status = ST_BAD_ADDR;
        end else begin
            case (w_op)
                OP_WRITE: begin
                    w_result = w_data;
                    w_we     = (r_state == S_EXEC);
                end
                OP_READ:  w_result = w_rd_data;
                OP_ADD: begin
                    w_result = w_sum;
                    w_wdata  = w_sum;
                    w_we     = (r_state == S_EXEC);
                end
                default:  w_result = 32'd0;
            endcase
        end
    end

    msg_regfile #(
        .N_REGS     (N_REGS),
        .W_LOG_REGS (W_LOG_REGS)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_rd_addr (w_addr[W_LOG_REGS-1:0]),
        .o_rd_data (w_rd_data),
        .i_we      (w_we),
        .i_wr_addr (w_addr[W_LOG_REGS-1:0]),
        .i_wr_data (w_wdata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic; one request in flight at a time
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (i_in_msg_rdy) w_state_nxt = S_ACK;
            S_ACK:  w_state_nxt = S_EXEC;
            S_EXEC: w_state_nxt = (w_op == OP_NOP) ? S_IDLE : S_RESP;
            S_RESP: if (i_out_msg_ack) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state
    always_comb begin
        i_in_msg_ack  = 1'b0;
        i_out_msg_rdy = 1'b0;
        busy          = 1'b0;
        case (r_state)
            S_ACK:  begin i_in_msg_ack  = 1'b1; busy = 1'b1; end
            S_EXEC: busy = 1'b1;
            S_RESP: begin i_out_msg_rdy = 1'b1; busy = 1'b1; end
            default: busy = 1'b0;
        endcase
    end

    // Request capture, response register and saturating counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_msg_q  <= '0;
            r_resp   <= '0;
            r_n_msgs <= 16'd0;
            r_n_errs <= 16'd0;
        end else begin
            if (r_state == S_IDLE && i_in_msg_rdy) begin
                r_msg_q <= i_in_msg;
            end
            if (r_state == S_ACK && r_n_msgs != 16'hFFFF) begin
                r_n_msgs <= r_n_msgs + 16'd1;
            end
            if (r_state == S_EXEC && w_op != OP_NOP) begin
                r_resp <= {w_op, w_status, w_addr, w_tag, w_result};
                if (w_status != ST_OK && r_n_errs != 16'hFFFF) begin
                    r_n_errs <= r_n_errs + 16'd1;
                end
            end
        end
    end

    assign i_out_msg = r_resp;
    assign n_msgs    = r_n_msgs;
    assign n_errs    = r_n_errs;

endmodule

`default_nettype wire

// File: tb/tb_axi_msg_responder.sv
// ============================================================================
// Module      : tb_axi_msg_responder
// Description : Directed self-checking bench for axi_msg_responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_msg_responder;

    logic        clk;
    logic        rst;
    logic        i_in_msg_rdy;
    logic [63:0] i_in_msg;
    logic        i_in_msg_ack;
    logic        i_out_msg_rdy;
    logic [63:0] i_out_msg;
    logic        i_out_msg_ack;
    logic        busy;
    logic [15:0] n_msgs;
    logic [15:0] n_errs;

    int n_checks = 0;
    int n_errors = 0;

    axi_msg_responder #(
        .W_MSG      (64),
        .N_REGS     (16),
        .W_LOG_REGS (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_in_msg_rdy  (i_in_msg_rdy),
        .i_in_msg      (i_in_msg),
        .i_in_msg_ack  (i_in_msg_ack),
        .i_out_msg_rdy (i_out_msg_rdy),
        .i_out_msg     (i_out_msg),
        .i_out_msg_ack (i_out_msg_ack),
        .busy          (busy),
        .n_msgs        (n_msgs),
        .n_errs        (n_errs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Offer one request, follow it through to its response (or its absence)
    task automatic req(input logic [3:0] op, input logic [7:0] addr,
                       input logic [15:0] tag, input logic [31:0] data,
                       input bit has_resp, input bit do_ack,
                       input logic [63:0] exp);
        bit seen;
        seen         = 1'b0;
        i_in_msg     = {op, 4'h0, addr, tag, data};
        i_in_msg_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i_in_msg_ack) begin
                seen = 1'b1;
                break;
            end
        end
        chk("in_ack_seen", 64'(seen), 64'd1);
        i_in_msg_rdy = 1'b0;
        @(negedge clk);
        chk("in_ack_width", 64'(i_in_msg_ack), 64'd0);
        chk("out_rdy_early", 64'(i_out_msg_rdy), 64'd0);
        @(negedge clk);
        if (has_resp) begin
            chk("out_rdy", 64'(i_out_msg_rdy), 64'd1);
            chk("out_msg", i_out_msg, exp);
            if (do_ack) begin
                i_out_msg_ack = 1'b1;
                @(negedge clk);
                i_out_msg_ack = 1'b0;
                chk("out_rdy_drop", 64'(i_out_msg_rdy), 64'd0);
            end
        end else begin
            chk("nop_no_resp", 64'(i_out_msg_rdy), 64'd0);
            chk("nop_idle", 64'(busy), 64'd0);
        end
    endtask

    initial begin
        rst           = 1'b1;
        i_in_msg_rdy  = 1'b0;
        i_in_msg      = 64'd0;
        i_out_msg_ack = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_in_ack", 64'(i_in_msg_ack), 64'd0);
        chk("rst_out_rdy", 64'(i_out_msg_rdy), 64'd0);
        chk("rst_out_msg", i_out_msg, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_n_msgs", 64'(n_msgs), 64'd0);
        chk("rst_n_errs", 64'(n_errs), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Stray ack while idle
        i_out_msg_ack = 1'b1;
        @(negedge clk);
        i_out_msg_ack = 1'b0;
        chk("idle_ack_rdy", 64'(i_out_msg_rdy), 64'd0);
        chk("idle_ack_busy", 64'(busy), 64'd0);
        chk("idle_ack_msg", i_out_msg, 64'd0);

        // WRITE then READ
        req(4'd1, 8'h05, 16'h00AA, 32'hDEADBEEF, 1, 1, 64'h100500AADEADBEEF);
        req(4'd2, 8'h05, 16'h00AB, 32'h00000000, 1, 1, 64'h200500ABDEADBEEF);
        chk("n_msgs_2", 64'(n_msgs), 64'd2);
        chk("n_errs_0", 64'(n_errs), 64'd0);

        // ADD wrap-around
        req(4'd1, 8'h03, 16'h0001, 32'hFFFFFFFF, 1, 1, 64'h10030001FFFFFFFF);
        req(4'd3, 8'h03, 16'h0002, 32'h00000002, 1, 1, 64'h3003000200000001);

        // Errors
        req(4'd7, 8'h01, 16'h0003, 32'h00000055, 1, 1, 64'h7201000300000000);
        req(4'd2, 8'h10, 16'h0004, 32'h00000000, 1, 1, 64'h2110000400000000);
        chk("n_errs_2", 64'(n_errs), 64'd2);
        req(4'd1, 8'h10, 16'h0007, 32'h12345678, 1, 1, 64'h1110000700000000);
        chk("n_errs_3", 64'(n_errs), 64'd3);
        req(4'd2, 8'h05, 16'h0005, 32'h0, 1, 1, 64'h20050005DEADBEEF);
        req(4'd2, 8'h03, 16'h0006, 32'h0, 1, 1, 64'h2003000600000001);
        req(4'd2, 8'h00, 16'h0008, 32'h0, 1, 1, 64'h2000000800000000);
        chk("n_msgs_10", 64'(n_msgs), 64'd10);

        // Backpressure with a second request already waiting
        begin
            bit seen;
            seen         = 1'b0;
            i_in_msg     = 64'h2005001000000000;
            i_in_msg_rdy = 1'b1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (i_in_msg_ack) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("bp_ack_a", 64'(seen), 64'd1);
            i_in_msg = 64'h10070011CAFEF00D;
            repeat (2) @(negedge clk);
            for (int i = 0; i < 10; i++) begin
                chk("bp_hold_rdy", 64'(i_out_msg_rdy), 64'd1);
                chk("bp_hold_msg", i_out_msg, 64'h20050010DEADBEEF);
                chk("bp_no_pop", 64'(i_in_msg_ack), 64'd0);
                @(negedge clk);
            end
            i_out_msg_ack = 1'b1;
            @(negedge clk);
            i_out_msg_ack = 1'b0;
            chk("bp_rdy_drop", 64'(i_out_msg_rdy), 64'd0);
            chk("bp_ack_b_early", 64'(i_in_msg_ack), 64'd0);
            @(negedge clk);
            chk("bp_ack_b", 64'(i_in_msg_ack), 64'd1);
            i_in_msg_rdy = 1'b0;
            @(negedge clk);
            chk("bp_ack_b_width", 64'(i_in_msg_ack), 64'd0);
            @(negedge clk);
            chk("bp_resp_b_rdy", 64'(i_out_msg_rdy), 64'd1);
            chk("bp_resp_b", i_out_msg, 64'h10070011CAFEF00D);
            i_out_msg_ack = 1'b1;
            @(negedge clk);
            i_out_msg_ack = 1'b0;
        end

        // NOP produces a pop but no response
        req(4'd0, 8'h05, 16'h0020, 32'h00000099, 0, 0, 64'd0);
        chk("n_msgs_13", 64'(n_msgs), 64'd13);
        chk("n_errs_3b", 64'(n_errs), 64'd3);

        // Reset while a response is pending
        req(4'd1, 8'h09, 16'h0030, 32'h11111111, 1, 0, 64'h1009003011111111);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_rdy", 64'(i_out_msg_rdy), 64'd0);
        chk("mid_rst_msg", i_out_msg, 64'd0);
        chk("mid_rst_n_msgs", 64'(n_msgs), 64'd0);
        repeat (3) @(negedge clk);
        chk("mid_rst_no_resp", 64'(i_out_msg_rdy), 64'd0);
        req(4'd2, 8'h05, 16'h0031, 32'h0, 1, 1, 64'h2005003100000000);
        req(4'd2, 8'h09, 16'h0032, 32'h0, 1, 1, 64'h2009003200000000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi_msg_responder.md
# axi_msg_responder

Inside-side endpoint for the accelerator message FIFO bridge. It pops 64-bit request messages from the bridge's IN FIFO using the rdy/ack handshake. It executes each request against a small 32-bit register file and pushes one response message per request into the bridge's OUT FIFO. It is the responder for host-initiated messages and connects port-for-port to the bridge's `i_*` signals.

## Interface
- `W_MSG`, default 64: message width; fixed, field map below assumes 64.
- `N_REGS`, default 16: number of 32-bit registers.
- `W_LOG_REGS`, default 4: log2(`N_REGS`).
- `clk`  in  1: clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `i_in_msg_rdy`  in  1: head of IN FIFO valid.
- `i_in_msg`  in  `W_MSG`: head of IN FIFO.
- `i_in_msg_ack`  out  1: one-cycle pulse; pops IN FIFO head.
- `i_out_msg_rdy`  out  1: response valid; held until acked.
- `i_out_msg`  out  `W_MSG`: response message; stable while `i_out_msg_rdy`.
- `i_out_msg_ack`  in  1: bridge accepted response.
- `busy`  out  1: high in any state other than IDLE.
- `n_msgs`  out  16: requests consumed; saturates at 0xFFFF.
- `n_errs`  out  16: error responses sent; saturates at 0xFFFF.

## Operation
- Request fields:
  - [63:60] op
  - [59:56] reserved (ignored)
  - [55:48] addr
  - [47:32] tag
  - [31:0] data
- Response fields:
  - [63:60] op echoed
  - [59:56] status
  - [55:48] addr echoed
  - [47:32] tag echoed
  - [31:0] result
- Ops:
  - 0 NOP: no register change, no response.
  - 1 WRITE: reg[addr] = data; result = data.
  - 2 READ: result = reg[addr].
  - 3 ADD: reg[addr] = reg[addr] + data, mod 2^32; result = new value.
  - 4..15: BAD_OP.
- Status codes:
  - 0 OK.
  - 1 BAD_ADDR: addr >= `N_REGS`; checked only for ops 1-3.
  - 2 BAD_OP.
- Error handling: any non-OK status leaves registers unchanged, sets result = 0 and increments `n_errs`.
- FSM states:
  - IDLE: if `i_in_msg_rdy`, capture `i_in_msg` into msg_q, drive `i_in_msg_ack`=1 → ACK.
  - ACK: drive `i_in_msg_ack`=0, increment `n_msgs` → EXEC. `i_in_msg_rdy` is not sampled here; the FIFO may still show the stale head.
  - EXEC: commit the register write, register the response. NOP → IDLE; otherwise `i_out_msg_rdy`=1 → RESP.
  - RESP: hold `i_out_msg` and `i_out_msg_rdy`. When `i_out_msg_ack` is sampled high, drop `i_out_msg_rdy` → IDLE.
- Ordering: strictly one request in flight. The next request is popped only after the previous response is acked.
- `i_out_msg_ack` outside RESP is ignored.
- Reset values: all outputs 0, including `i_out_msg`. All registers 0, counters 0, state IDLE.
- Reset mid-operation: a captured-but-unanswered request is discarded. No response is emitted after reset.

## Timing
- Edge k: IDLE samples `i_in_msg_rdy`=1. `i_in_msg_ack` is high during cycle k→k+1, exactly one cycle.
- Edge k+2: `i_out_msg_rdy` rises with a valid `i_out_msg`. Request-to-response latency is 2 cycles.
- Register write visible to a subsequent READ: the READ's response carries the new value.
- `i_out_msg_ack` sampled at edge m: `i_out_msg_rdy` is low from edge m. The earliest next pop is a sample at edge m+1.
- NOP throughput: one request per 3 cycles.
- Non-NOP throughput: one request per 3 cycles plus bridge ack latency.
- Counters update at edge k+1. `n_errs` updates at edge k+2.

## Structure
- Package `axi_msg_pkg` contains:
  - op enum (NOP/WRITE/READ/ADD).
  - status enum (OK/BAD_ADDR/BAD_OP).
  - field bit-position localparams.
  - FSM state enum (IDLE/ACK/EXEC/RESP).
  - `W_MSG`.
- Sub-module `msg_regfile`: `N_REGS`×32, one combinational read port, one synchronous write port, synchronous reset to 0.
- Top module holds the FSM, msg_q, response register and counters.

## Test plan
- Reset: hold `rst` 2 cycles → every output 0, `busy`=0; `i_out_msg_ack` pulsed in IDLE → no effect.
- WRITE then READ: request op=1, addr=5, tag=0x00AA, data=0xDEADBEEF, ack each response → response 0x1_0_05_00AA_DEADBEEF. Then request op=2, addr=5, tag=0x00AB → response 0x2_0_05_00AB_DEADBEEF. Then `n_msgs`=2, `n_errs`=0.
- ADD wrap: WRITE reg3=0xFFFFFFFF, then ADD addr=3, data=2 → result 0x00000001, status 0.
- Errors:
  - op=7 → status 2, result 0.
  - op=2 with addr=16 → status 1, result 0.
  - Afterwards `n_errs`=2 and registers unchanged.
- Backpressure/ordering:
  - Delay `i_out_msg_ack` 10 cycles with a second request already queued → response held stable, no second `i_in_msg_ack` until after the ack.
  - Each `i_in_msg_ack` is exactly 1 cycle wide.
- NOP and reset mid-op:
  - NOP → `i_in_msg_ack` pulse, no `i_out_msg_rdy`.
  - Assert `rst` during RESP → `i_out_msg_rdy` 0 next edge, READ of any register returns 0.
